// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: register addresses and bus address width.
`timescale 1ns/1ps
package gpio_pkg;

    localparam int unsigned GPIO_ADDR_W = 3;

    typedef enum logic [GPIO_ADDR_W-1:0] {
        GPIO_OUT    = 3'd0,
        GPIO_DIR    = 3'd1,
        GPIO_IN     = 3'd2,
        GPIO_RISE   = 3'd3,
        GPIO_FALL   = 3'd4,
        GPIO_IRQ_EN = 3'd5
    } gpio_addr_e;

endpackage

// File: rtl/gpio_if.sv
// Core-side register bus of the GPIO port: strobed reads/writes plus interrupt line.
`timescale 1ns/1ps
interface gpio_if #(
    parameter int unsigned WIDTH = 4
) ();
    import gpio_pkg::*;

    logic [GPIO_ADDR_W-1:0] addr_in;
    logic                   wr_en_in;
    logic [WIDTH-1:0]       wdata_in;
    logic                   rd_en_in;
    logic [WIDTH-1:0]       rdata_out;
    logic                   rvalid_out;
    logic                   irq_out;

    modport master (
        output addr_in, wr_en_in, wdata_in, rd_en_in,
        input  rdata_out, rvalid_out, irq_out
    );

    modport slave (
        input  addr_in, wr_en_in, wdata_in, rd_en_in,
        output rdata_out, rvalid_out, irq_out
    );
endinterface

// File: rtl/gpio_debounce.sv
// One pad input: multi-flop synchroniser followed by a stable-count debouncer.
// rise_out/fall_out pulse combinationally in the cycle whose edge updates level_out.
`timescale 1ns/1ps
module gpio_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic pad_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);
    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   sync_lvl;
    logic                   accept;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign accept   = (sync_lvl != deb_q) && (cnt_q == CNT_LAST);

    // Shift the synchroniser; count mismatch cycles and accept the new level on the last one.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        deb_d  = deb_q;
        cnt_d  = '0;
        if (sync_lvl != deb_q) begin
            if (accept) begin
                deb_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign level_out = deb_q;
    assign rise_out  = accept & sync_lvl;
    assign fall_out  = accept & ~sync_lvl;
endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO: register file, pad tristates, debounced inputs,
// write-1-to-clear edge flags and a gated interrupt line.
`timescale 1ns/1ps
module gpio_port
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    gpio_if.slave           bus,
    inout  wire [WIDTH-1:0] pad_io
);
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] deb_lvl;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        gpio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .pad_in   (pad_io[i]),
            .level_out(deb_lvl[i]),
            .rise_out (rise_evt[i]),
            .fall_out (fall_evt[i])
        );

        assign pad_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Register writes; an edge event ORed in after the clear makes set win over W1C.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        rise_d   = rise_q | rise_evt;
        fall_d   = fall_q | fall_evt;
        if (bus.wr_en_in) begin
            case (bus.addr_in)
                GPIO_OUT:    out_d    = bus.wdata_in;
                GPIO_DIR:    dir_d    = bus.wdata_in;
                GPIO_RISE:   rise_d   = (rise_q & ~bus.wdata_in) | rise_evt;
                GPIO_FALL:   fall_d   = (fall_q & ~bus.wdata_in) | fall_evt;
                GPIO_IRQ_EN: irq_en_d = bus.wdata_in;
                default:     ;
            endcase
        end
    end

    // Read mux over current register values, so a same-cycle write is not yet visible.
    always_comb begin
        rvalid_d = bus.rd_en_in;
        rdata_d  = rdata_q;
        if (bus.rd_en_in) begin
            case (bus.addr_in)
                GPIO_OUT:    rdata_d = out_q;
                GPIO_DIR:    rdata_d = dir_q;
                GPIO_IN:     rdata_d = deb_lvl;
                GPIO_RISE:   rdata_d = rise_q;
                GPIO_FALL:   rdata_d = fall_q;
                GPIO_IRQ_EN: rdata_d = irq_en_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    // Register file and read data state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_q    <= '0;
            dir_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rdata_out  = rdata_q;
    assign bus.rvalid_out = rvalid_q;
    assign bus.irq_out    = |((rise_q | fall_q) & irq_en_q);
endmodule

// File: doc/gpio_port.md
# gpio_port

Memory-mapped general-purpose I/O block between the processor core's data bus and the `d0_io..d3_io` pads of the `processor` top level. It owns the pad tristate drivers, synchronises and debounces pad inputs, and latches rising/falling edge events into write-1-to-clear flags. Edge flags are gated into a single interrupt line back to the core.

## Interface
- `WIDTH`, 4: number of pads.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required to accept a new level, ≥1.
- `clk_in` in 1: single clock; all state on its rising edge.
- `rst_in` in 1: reset, asynchronous assert, active-low.
- `addr_in` in 3: register select.
- `wr_en_in` in 1: write strobe, one cycle.
- `wdata_in` in WIDTH: write data.
- `rd_en_in` in 1: read strobe, one cycle.
- `rdata_out` out WIDTH: registered read data.
- `rvalid_out` out 1: high the cycle `rdata_out` is valid.
- `irq_out` out 1: OR of enabled pending flags.
- `pad_io` inout WIDTH: pads; bit i maps to `d<i>_io`.

## Operation
- Register map: 0 OUT (rw), 1 DIR (rw, 1=output), 2 IN (ro, debounced level), 3 RISE (W1C), 4 FALL (W1C), 5 IRQ_EN (rw); 6–7 read 0, writes ignored. Writes to IN are ignored.
- Pad drive: `pad_io[i]` = OUT[i] when DIR[i]=1, else Z.
- Per pad: SYNC_STAGES-flop synchroniser → debouncer. Debouncer holds `deb` and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever `sync == deb`.
  - While `sync != deb`, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 with a mismatch still present, `deb` takes `sync` at the next edge and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches `deb`.
- Input path applies to output pads as well; IN reflects the actual pad level.
- Flags: RISE[i] sets on the edge where `deb[i]` goes 0→1; FALL[i] sets on the edge where `deb[i]` goes 1→0.
- Writing 1 clears a flag bit; writing 0 leaves it unchanged. If a set and a clear hit the same bit on the same cycle, set wins.
- `irq_out` = |((RISE | FALL) & IRQ_EN). It is combinational from registers.
- Simultaneous `wr_en_in` and `rd_en_in`: both execute. A read returns the pre-write value.

## Timing
- Reset values: OUT=0, DIR=0 (all inputs, pads Z), RISE=FALL=0, IRQ_EN=0, sync and `deb` all 0, counters 0, `rdata_out`=0, `rvalid_out`=0, `irq_out`=0.
- Reset asserted mid-debounce discards count and flags immediately.
- A pad held high through reset produces RISE after SYNC_STAGES+DEBOUNCE_CYCLES edges post-release. This is intended; software clears it.
- Read latency: `rd_en_in` sampled at edge k → `rdata_out`/`rvalid_out` valid after edge k, for one cycle. `rdata_out` holds its value afterwards.
- Write latency: register updates at the sampling edge. The pad drive changes in the cycle after that edge.
- Pad-to-IN latency: SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the pad level is first sampled stable. Flag and `irq_out` change on the same edge as `deb`.
- Back-to-back reads and writes are allowed every cycle; there is no stall.

## Structure
- Package `gpio_pkg`: address constants `GPIO_OUT=3'd0 … GPIO_IRQ_EN=3'd5` and the address width.
- Sub-module `gpio_debounce`: one pad's synchroniser, counter and `deb`, with a 1-bit rise/fall pulse output. It is instantiated WIDTH times via generate.
- `gpio_port` holds the register file, read mux, W1C logic, IRQ reduction and tristate assigns.

## Test plan
- Reset: hold `rst_in`=0, pads driven 4'b0000 externally → all outputs 0, `pad_io` undriven. Release, read addr 2 → `rdata_out`=4'b0000, `rvalid_out` high exactly 1 cycle.
- Output drive: write DIR=4'b0011, OUT=4'b0101 → `pad_io`[1:0]=2'b01 next cycle, [3:2]=Z. Read IN after 6 cycles → bits[1:0]=01.
- Debounce: drive pad2 high for 3 cycles then low → IN[2] stays 0, RISE=0. Drive high for 4+ cycles → IN[2]=1 exactly 6 edges after first sampled, RISE=4'b0100.
- IRQ: IRQ_EN=4'b0100, then pad2 1→0 → FALL=4'b0100, `irq_out`=1. Write FALL=4'b0100 → `irq_out`=0 next cycle. Write FALL=4'b1011 → no effect.
- Set/clear collision: W1C write to RISE bit0 on the same edge as pad0's debounced rise → RISE[0] remains 1.
- Read/write collision: OUT=4'hA, then same-cycle write OUT=4'h5 and read addr 0 → `rdata_out`=4'hA. Next read → 4'h5. Reads of addr 6/7 return 0.
